ntps_mdio_arbiter: RTL and testbench
====================================

# ntps_mdio_arbiter

Clause-22 MDIO master that shares the single PHY management bus among several requesters, such as the per-port network paths and the host MDIO controller. Each requester submits a read or write transaction. The block picks one requester round-robin, serialises the 64-bit MDIO frame with an internally divided MDC, and returns read data and a status pulse to the requester that won. It sits between the requesters and the PHY pins and replaces static merging of MDIO outputs with sequenced, exclusive access.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- MDC_DIV, 25, clock cycles per MDC half-period (≥2); 25 gives 2.5 MHz at 125 MHz.
- axi_aclk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester transaction request.
- req_ready  out  NUM_REQ  one-hot accept.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_phy_addr  in  5*NUM_REQ  PHY address, packed; requester i uses bits [5i+:5].
- req_reg_addr  in  5*NUM_REQ  register address, packed.
- req_wdata  in  16*NUM_REQ  write data, packed.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- resp_rdata  out  16  read data; 0x0000 after a write.
- resp_error  out  1  read turnaround error; valid when any resp_valid bit is high.
- busy  out  1  high in any state other than IDLE.
- mdc  out  1  management clock.
- mdio_o  out  1  MDIO output data.
- mdio_t  out  1  tristate control; 1 = released (hi-Z).
- mdio_i  in  1  MDIO input, asynchronous.

## Operation
- States: IDLE, FRAME, RESP.
- Reset values: state IDLE, mdc 0, mdio_o 1, mdio_t 1, busy 0, req_ready 0, resp_valid 0, resp_rdata 0, resp_error 0, grant pointer NUM_REQ-1.
- IDLE:
  - req_ready is combinational and one-hot: the first requester with req_valid high, searching from pointer+1 with wrap-around.
  - On the edge where req_valid[g] and req_ready[g] are both high: capture write/phy/reg/wdata for g, set pointer = g, go to FRAME.
- FRAME: 64 bits, MSB-first.
  - Bits 0–31: preamble, all 1.
  - Bits 32–33: ST = 01.
  - Bits 34–35: OP = 01 for write, 10 for read.
  - Bits 36–40: PHYAD. Bits 41–45: REGAD.
  - Bits 46–47: TA = 10 for write.
  - Bits 48–63: DATA.
  - Each bit lasts 2*MDC_DIV cycles: mdc 0 for MDC_DIV cycles, then mdc 1 for MDC_DIV cycles.
  - mdio_o changes only at the start of a bit, while mdc is low.
- mdio_t:
  - 0 for bits 0–45 on every frame.
  - Write: 0 through bit 63.
  - Read: 1 from bit 46 through bit 63.
- Read sampling:
  - mdio_i passes through a 2-flop synchroniser.
  - The synchronised value is sampled on the edge where mdc rises within bits 47–63.
  - Bit 47 sampled as 1 sets resp_error.
  - Bits 48–63 shift into rdata, MSB first.
- RESP: lasts one cycle.
  - resp_valid[g] = 1; resp_rdata and resp_error are driven.
  - Return to IDLE next cycle; mdc 0, mdio_t 1, mdio_o 1.
- Requesters other than g keep waiting while the bus is busy. req_valid deasserted before acceptance is not an error.
- Reset during any state aborts the frame immediately with no response pulse. The next grant starts from requester 0.

## Timing
- Acceptance edge = cycle 0.
- FRAME occupies cycles 1 .. 128*MDC_DIV.
- resp_valid is high in cycle 128*MDC_DIV+1.
- Earliest next acceptance is cycle 128*MDC_DIV+2, since req_ready is 0 while busy.
- mdc period = 2*MDC_DIV cycles, 50% duty, no glitches. mdc stays 0 outside FRAME.
- resp_rdata and resp_error hold their values until the next RESP.

## Test plan
- Write, MDC_DIV=3, requester 0, phy=1, reg=0, wdata=0x1140:
  - mdio_o bits = 32 ones, then 0101 00001 00000 10 0001000101000000.
  - mdio_t is 0 throughout the frame.
  - resp_valid = 0001 at cycle 385; rdata 0x0000; error 0.
- Read, requester 2, phy=3, reg=2; PHY model drives TA bit 47 = 0 and data 0x796D on the rising edges of bits 47–63:
  - mdio_t rises at the start of bit 46.
  - resp_rdata = 0x796D; error 0; resp_valid = 0100.
- Read with no PHY (mdio_i held at 1):
  - resp_error 1, resp_rdata 0xFFFF.
- Requesters 0, 1 and 3 all held valid:
  - Grant order 0, 1, 3, 0, …
  - No overlap of frames; exactly one resp_valid pulse per accepted request.
- Reset asserted mid-frame at bit 40:
  - mdc, mdio_o, mdio_t, busy and resp_valid return to their reset values immediately.
  - No resp_valid pulse follows.
  - A subsequent request from requester 1 completes normally.
- MDC_DIV=2:
  - mdc period is 4 cycles.
  - mdio_o never changes while mdc is high.

Source files
------------

// File: rtl/ntps_mdio_arbiter_if.sv
// ntps_mdio_arbiter_if: requester handshake, response and MDIO pin signals of the MDIO arbiter
interface ntps_mdio_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [5*NUM_REQ-1:0]  req_phy_addr;
  logic [5*NUM_REQ-1:0]  req_reg_addr;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [15:0]           resp_rdata;
  logic                  resp_error;
  logic                  busy;
  logic                  mdc;
  logic                  mdio_o;
  logic                  mdio_t;
  logic                  mdio_i;
  modport slave (
    input  req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata, mdio_i,
    output req_ready, resp_valid, resp_rdata, resp_error, busy, mdc, mdio_o, mdio_t
  );
  modport master (
    output req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata, mdio_i,
    input  req_ready, resp_valid, resp_rdata, resp_error, busy, mdc, mdio_o, mdio_t
  );
endinterface

// File: rtl/ntps_mdio_arbiter.sv
// ntps_mdio_arbiter: round-robin shared Clause-22 MDIO master with internally divided MDC
module ntps_mdio_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MDC_DIV = 25
) (
  input logic axi_aclk,
  input logic reset,
  ntps_mdio_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(2 * MDC_DIV);
  localparam logic [CW-1:0] HALF = CW'(MDC_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(2 * MDC_DIV - 1);
  typedef enum logic [1:0] {IDLE, FRAME, RESP} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_q, bit_d;
  logic [63:0]   frame_q, frame_d;
  logic          wr_q, wr_d;
  logic          mdc_q, mdc_d, mdo_q, mdo_d, mdt_q, mdt_d;
  logic [1:0]    sync_q;
  logic          err_q, err_d, rerr_q, rerr_d;
  logic [15:0]   rx_q, rx_d, rdata_q, rdata_d;
  logic          accept, sel_wr;
  logic [4:0]    sel_phy, sel_reg;
  logic [15:0]   sel_wd;
  // Walk downward so the requester closest after the pointer is written last and wins.
  always_comb begin
    gidx = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) gidx = PW'((int'(ptr_q) + k) % NUM_REQ);
  end
  assign accept  = state_q == IDLE && |bus.req_valid;
  assign sel_wr  = bus.req_write[gidx];
  assign sel_phy = bus.req_phy_addr[5*int'(gidx) +: 5];
  assign sel_reg = bus.req_reg_addr[5*int'(gidx) +: 5];
  assign sel_wd  = bus.req_wdata[16*int'(gidx) +: 16];
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    wr_d    = wr_q;
    mdc_d   = mdc_q;
    mdo_d   = mdo_q;
    mdt_d   = mdt_q;
    err_d   = err_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = FRAME;
        ptr_d   = gidx;
        wr_d    = sel_wr;
        frame_d = {32'hFFFF_FFFF, 2'b01, sel_wr ? 2'b01 : 2'b10, sel_phy, sel_reg,
                   sel_wr ? {2'b10, sel_wd} : 18'h3_FFFF};
        cnt_d   = '0;
        bit_d   = '0;
        mdc_d   = 1'b0;
        mdo_d   = 1'b1;
        mdt_d   = 1'b0;
        err_d   = 1'b0;
        rx_d    = '0;
      end
      FRAME: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        mdc_d = cnt_d >= CW'(MDC_DIV);
        // Sample on the edge that raises mdc.
        if (cnt_q == HALF && bit_q == 6'd47) err_d = sync_q[1];
        if (cnt_q == HALF && bit_q >= 6'd48) rx_d = {rx_q[14:0], sync_q[1]};
        if (cnt_q == LAST) begin
          bit_d = bit_q + 1'b1;
          mdo_d = frame_q[~bit_d];
          mdt_d = !wr_q && bit_q >= 6'd45;
        end
        if (cnt_q == LAST && bit_q == 6'd63) begin
          state_d = RESP;
          mdo_d   = 1'b1;
          mdt_d   = 1'b1;
          rdata_d = wr_q ? '0 : rx_q;
          rerr_d  = !wr_q && err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge axi_aclk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      wr_q    <= 1'b0;
      mdc_q   <= 1'b0;
      mdo_q   <= 1'b1;
      mdt_q   <= 1'b1;
      sync_q  <= '1;
      err_q   <= 1'b0;
      rx_q    <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      wr_q    <= wr_d;
      mdc_q   <= mdc_d;
      mdo_q   <= mdo_d;
      mdt_q   <= mdt_d;
      sync_q  <= {sync_q[0], bus.mdio_i};
      err_q   <= err_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  assign bus.req_ready  = accept ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx : '0;
  assign bus.resp_valid = (state_q == RESP) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << ptr_q : '0;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = rerr_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.mdc        = mdc_q;
  assign bus.mdio_o     = mdo_q;
  assign bus.mdio_t     = mdt_q;
endmodule

// File: tb/tb_ntps_mdio_arbiter.sv
// tb_ntps_mdio_arbiter: table, directed and random checks of the MDIO arbiter against a frame-level model
module tb_ntps_mdio_arbiter;
  localparam int N  = 4;
  localparam int D  = 3;
  localparam int FC = 128 * D;
  typedef struct {
    int          g;
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic        present;
    logic [15:0] pdata;
    logic [63:0] frame;
    logic [63:0] mask;
    logic [15:0] rdata;
    logic        err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int ptr_m = N - 1;
  logic [N-1:0] rv = '0;
  logic        rw   [N];
  logic [4:0]  rphy [N];
  logic [4:0]  rreg [N];
  logic [15:0] rwd  [N];
  ntps_mdio_arbiter_if #(.NUM_REQ(N)) bus ();
  ntps_mdio_arbiter_if #(.NUM_REQ(N)) bus2 ();
  ntps_mdio_arbiter #(.NUM_REQ(N), .MDC_DIV(D)) dut (.axi_aclk(clk), .reset(rst), .bus(bus));
  ntps_mdio_arbiter #(.NUM_REQ(N), .MDC_DIV(2)) dut2 (.axi_aclk(clk), .reset(rst), .bus(bus2));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic int pick(input int p, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = rv[i];
      bus.req_write[i]           = rw[i];
      bus.req_phy_addr[5*i +: 5] = rphy[i];
      bus.req_reg_addr[5*i +: 5] = rreg[i];
      bus.req_wdata[16*i +: 16]  = rwd[i];
    end
  endtask
  // One whole transaction: predicted grant, cycle-by-cycle waveform, PHY replies and response.
  task automatic do_one(input logic present, input logic [15:0] pdata, input logic hold,
                        output int g, output logic [63:0] obs, output logic [15:0] rd, output logic er);
    int t = 0;
    int bad = 0;
    int b, ph, x;
    logic w;
    logic [63:0] fr;
    logic [N-1:0] oh;
    logic [15:0] exp_rd;
    logic exp_er;
    obs = '0;
    rd = '0;
    er = 1'b0;
    g = pick(ptr_m, rv);
    drive();
    #1;
    while (!(|(bus.req_valid & bus.req_ready)) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20 || g < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no req_ready, expected grant %0d", g);
      g = -1;
      return;
    end
    oh = '0;
    oh[g] = 1'b1;
    chk("grant", bus.req_ready, oh);
    ptr_m = g;
    w = rw[g];
    fr = {32'hFFFF_FFFF, 2'b01, w ? 2'b01 : 2'b10, rphy[g], rreg[g], 2'b10, w ? rwd[g] : 16'h0};
    exp_rd = w ? 16'h0 : present ? pdata : 16'hFFFF;
    exp_er = !w && !present;
    for (int c = 1; c <= FC + 2; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) begin
        rv[g] = 1'b0;
        drive();
      end
      if (c <= FC) begin
        b = (c - 1) / (2 * D);
        ph = (c - 1) % (2 * D);
        if (bus.mdc !== (ph >= D) || bus.mdio_t !== (!w && b >= 46) ||
            ((w || b < 46) && bus.mdio_o !== fr[63-b]) || bus.busy !== 1'b1 ||
            bus.resp_valid !== '0 || bus.req_ready !== '0) bad++;
        if (ph == D) begin
          obs[63-b] = bus.mdio_o;
          x = b + 1;
          bus.mdio_i = (!present || x < 47 || x > 63) ? 1'b1 : (x == 47) ? 1'b0 : pdata[63-x];
        end
      end else if (c == FC + 1) begin
        chk("resp_valid", {bus.resp_valid, bus.busy, bus.mdc}, {oh, 2'b10});
        chk("resp_data", {bus.resp_rdata, bus.resp_error}, {exp_rd, exp_er});
        rd = bus.resp_rdata;
        er = bus.resp_error;
        bus.mdio_i = 1'b1;
      end else begin
        chk("after_resp", {bus.resp_valid, bus.busy, bus.mdc, bus.mdio_t, bus.mdio_o, bus.resp_rdata, bus.resp_error},
            {{N{1'b0}}, 4'b0011, exp_rd, exp_er});
      end
    end
    chk("frame_wave", bad, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t tbl [5];
    int order [4] = '{0, 1, 3, 0};
    int gg, t, pulses, rises, badp, chg, last;
    logic pm, po, pres;
    logic [63:0] obs;
    logic [15:0] rd, pd;
    logic er;
    tbl[0] = '{0, 1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0,
               {32'hFFFF_FFFF, 32'b0101_00001_00000_10_0001000101000000}, '1, 16'h0000, 1'b0};
    tbl[1] = '{2, 1'b0, 5'd3, 5'd2, 16'h0, 1'b1, 16'h796D,
               {32'hFFFF_FFFF, 4'b0110, 5'd3, 5'd2, 18'h0}, 64'hFFFF_FFFF_FFFC_0000, 16'h796D, 1'b0};
    tbl[2] = '{1, 1'b0, 5'd7, 5'd1, 16'h0, 1'b0, 16'h0,
               {32'hFFFF_FFFF, 4'b0110, 5'd7, 5'd1, 18'h0}, 64'hFFFF_FFFF_FFFC_0000, 16'hFFFF, 1'b1};
    tbl[3] = '{3, 1'b1, 5'd31, 5'd31, 16'h0001, 1'b0, 16'h0,
               {32'hFFFF_FFFF, 4'b0101, 5'd31, 5'd31, 2'b10, 16'h0001}, '1, 16'h0000, 1'b0};
    tbl[4] = '{0, 1'b0, 5'd0, 5'd31, 16'h0, 1'b1, 16'h8001,
               {32'hFFFF_FFFF, 4'b0110, 5'd0, 5'd31, 18'h0}, 64'hFFFF_FFFF_FFFC_0000, 16'h8001, 1'b0};
    for (int i = 0; i < N; i++) begin
      rw[i] = 1'b0;
      rphy[i] = '0;
      rreg[i] = '0;
      rwd[i] = '0;
    end
    drive();
    bus.mdio_i = 1'b1;
    bus2.req_valid = '0;
    bus2.req_write = '1;
    bus2.req_phy_addr = '0;
    bus2.req_reg_addr = '0;
    bus2.req_wdata = {N{16'hA5C3}};
    bus2.mdio_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.mdc, bus.mdio_o, bus.mdio_t, bus.busy, bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error},
        {4'b0110, {N{1'b0}}, {N{1'b0}}, 16'h0, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rv = '0;
      rw[tbl[i].g] = tbl[i].wr;
      rphy[tbl[i].g] = tbl[i].phy;
      rreg[tbl[i].g] = tbl[i].rg;
      rwd[tbl[i].g] = tbl[i].wd;
      rv[tbl[i].g] = 1'b1;
      do_one(tbl[i].present, tbl[i].pdata, 1'b0, gg, obs, rd, er);
      chk($sformatf("tbl%0d_grant", i), gg, tbl[i].g);
      chk($sformatf("tbl%0d_frame", i), obs & tbl[i].mask, tbl[i].frame & tbl[i].mask);
      chk($sformatf("tbl%0d_rdata", i), {rd, er}, {tbl[i].rdata, tbl[i].err});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = N - 1;
    rv = 4'b1011;
    for (int i = 0; i < N; i++) rw[i] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_one(1'b0, 16'h0, 1'b1, gg, obs, rd, er);
      chk($sformatf("rr_order%0d", k), gg, order[k]);
    end
    rv = '0;
    drive();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 1) == 1) begin
          rv[i] = 1'b1;
          rw[i] = 1'($urandom_range(0, 1));
          rphy[i] = 5'($urandom_range(0, 31));
          rreg[i] = 5'($urandom_range(0, 31));
          rwd[i] = 16'($urandom_range(0, 65535));
        end
      if (rv == '0) rv[$urandom_range(0, N - 1)] = 1'b1;
      pres = $urandom_range(0, 3) != 0;
      pd = 16'($urandom_range(0, 65535));
      do_one(pres, pd, 1'b0, gg, obs, rd, er);
    end
    rv = '0;
    drive();
    repeat (2) @(negedge clk);
    rv[2] = 1'b1;
    rw[2] = 1'b1;
    rphy[2] = 5'd9;
    rreg[2] = 5'd4;
    rwd[2] = 16'hABCD;
    drive();
    #1;
    t = 0;
    while (!bus.req_ready[2] && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    rv = '0;
    drive();
    repeat (40 * 2 * D) @(negedge clk);
    chk("rst_pre_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {bus.mdc, bus.mdio_o, bus.mdio_t, bus.busy, bus.resp_valid}, {4'b0110, {N{1'b0}}});
    @(negedge clk);
    rst = 1'b0;
    ptr_m = N - 1;
    pulses = 0;
    repeat (FC + 10) begin
      @(negedge clk);
      if (|bus.resp_valid) pulses++;
    end
    chk("rst_no_resp", pulses, 0);
    rv[1] = 1'b1;
    rw[1] = 1'b0;
    rphy[1] = 5'd1;
    rreg[1] = 5'd3;
    do_one(1'b1, 16'h5A3C, 1'b0, gg, obs, rd, er);
    chk("post_rst_grant", gg, 1);
    chk("post_rst_rdata", {rd, er}, {16'h5A3C, 1'b0});
    bus2.req_valid = 4'b0001;
    #1;
    t = 0;
    while (!bus2.req_ready[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("div2_ready", bus2.req_ready, 4'b0001);
    rises = 0;
    badp = 0;
    chg = 0;
    last = -1;
    pm = 1'b0;
    po = 1'b1;
    for (int c = 1; c <= 258; c++) begin
      @(negedge clk);
      if (c == 1) bus2.req_valid = '0;
      if (bus2.mdc && !pm) begin
        if (last >= 0 && c - last != 4) badp++;
        last = c;
        rises++;
      end
      if (bus2.mdc && bus2.mdio_o !== po) chg++;
      if (c == 257) chk("div2_resp", bus2.resp_valid, 4'b0001);
      pm = bus2.mdc;
      po = bus2.mdio_o;
    end
    chk("div2_rises", rises, 64);
    chk("div2_period", badp, 0);
    chk("div2_hold_high", chg, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
